// File: rtl/cic_filter.sv
// cic_filter: 3-stage Hogenauer CIC decimator, differential delay 1,
// runtime ratio R = 2^(os_sel+2), output normalized to unity DC gain.
// Optional build macro CIC_ROUND_EN: round-half-up normalization instead of
// truncation toward minus infinity.
module cic_filter #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,   // active-high synchronous reset
  input  logic [2:0]           os_sel,
  input  logic signed [DW-1:0] data_in,
  output logic signed [DW-1:0] data_out,
  output logic                 clk_div
);

  localparam int unsigned W  = DW + 27;  // 3 * log2(512) growth bits
  localparam int unsigned CW = 9;        // counter covers R-1 up to 511
  localparam int unsigned SW = 6;        // shift amount / bit index width

  logic [W-1:0]  i1, i2, i3;
  logic [W-1:0]  d1, d2, d3;
  logic [W-1:0]  din_ext_c;
  logic [W-1:0]  c1_c, c2_c, c3_c, rnd_c;
  logic [2:0]    os_act;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_last_c;
  logic [SW-1:0] shift_c;
  logic          strobe_c;

  // Ratio-dependent terms, comb chain and normalization
  always_comb begin
    din_ext_c  = {{(W-DW){data_in[DW-1]}}, data_in};
    cnt_last_c = CW'((32'd1 << (32'(os_act) + 32'd2)) - 32'd1);
    shift_c    = SW'(32'd3 * (32'(os_act) + 32'd2));
    strobe_c   = (cnt == cnt_last_c);
    c1_c       = i3 - d1;
    c2_c       = c1_c - d2;
    c3_c       = c2_c - d3;
`ifdef CIC_ROUND_EN
    rnd_c      = c3_c + (W'(1) << (shift_c - SW'(1)));
`else
    rnd_c      = c3_c;
`endif
  end

  // Integrator pipeline, free-running modulo 2^W
  always_ff @(posedge clk) begin
    if (reset_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= i1 + din_ext_c;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  // Decimation counter and ratio latch; a new ratio applies from the next period
  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt    <= '0;
      os_act <= os_sel;
    end else if (strobe_c) begin
      cnt    <= '0;
      os_act <= os_sel;
    end else begin
      cnt    <= cnt + CW'(1);
    end
  end

  // Comb delays and output register; the DW-bit window at the shift offset is
  // the low DW bits of the arithmetic right shift
  always_ff @(posedge clk) begin
    if (reset_n) begin
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      data_out <= '0;
      clk_div  <= 1'b0;
    end else begin
      clk_div <= strobe_c;
      if (strobe_c) begin
        d1       <= i3;
        d2       <= c1_c;
        d3       <= c2_c;
        data_out <= rnd_c[shift_c +: DW];
      end
    end
  end

endmodule

// File: tb/tb_cic_filter.sv
// tb_cic_filter: directed stimulus for cic_filter with a transfer-function
// model (binomial-weighted input history sampled at strobes, third difference,
// normalizing shift) checked every cycle, plus literal checks.
module tb_cic_filter;

  localparam int DW = 16;
  localparam int W  = DW + 27;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [2:0]           os_sel;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] data_out;
  logic                 clk_div;

  int n_tests = 0;
  int n_fail  = 0;

  cic_filter #(.DW(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .os_sel   (os_sel),
    .data_in  (data_in),
    .data_out (data_out),
    .clk_div  (clk_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: input history since reset, triple running sum at the last
  // three strobes, active ratio and position within the current period.
  int                   hist[$];
  logic [W-1:0]         p1 = '0, p2 = '0, p3 = '0;
  logic signed [DW-1:0] exp_out = '0;
  logic                 exp_div = 1'b0;
  int                   act = 0;
  int                   phase = 0;

  // Triple running sum seen at edge m: sum of x_i * (m-2-i)(m-1-i)/2
  function automatic logic [W-1:0] triple_sum(input int m);
    logic [W-1:0] acc;
    longint       w;
    acc = '0;
    for (int i = 1; i <= m - 3; i++) begin
      w   = longint'(m - 2 - i) * longint'(m - 1 - i) / 64'sd2;
      acc = acc + W'(w * longint'(hist[i-1]));
    end
    return acc;
  endfunction

  // Model update at each edge, then compare outputs shortly after
  always @(posedge clk) begin
    logic [W-1:0]        s_now, c3;
    logic signed [W-1:0] sc;
    int                  s;
    if (reset_n) begin
      hist.delete();
      p1 = '0; p2 = '0; p3 = '0;
      exp_out = '0;
      exp_div = 1'b0;
      act     = int'(os_sel);
      phase   = 0;
    end else begin
      if (phase == (1 << (act + 2)) - 1) begin
        s_now = triple_sum(hist.size() + 1);
        c3    = s_now - (p1 + p1 + p1) + (p2 + p2 + p2) - p3;
        s     = 3 * (act + 2);
`ifdef CIC_ROUND_EN
        c3    = c3 + (W'(1) << (s - 1));
`endif
        sc      = c3;
        sc      = sc >>> s;
        exp_out = sc[DW-1:0];
        exp_div = 1'b1;
        p3 = p2; p2 = p1; p1 = s_now;
        act   = int'(os_sel);
        phase = 0;
      end else begin
        exp_div = 1'b0;
        phase++;
      end
      hist.push_back(int'(data_in));
    end
    #1;
    check("model_clk_div", longint'(clk_div), longint'(exp_div));
    check("model_data_out", longint'(data_out), longint'(exp_out));
  end

  // Count negedges until the strobe is seen, bounded
  task automatic wait_strobe(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!clk_div && cycles < budget);
    if (!clk_div) check("strobe_timeout", 0, 1);
  endtask

  task automatic do_reset(input logic [2:0] sel, input logic signed [DW-1:0] x);
    @(negedge clk);
    reset_n = 1'b1;
    os_sel  = sel;
    data_in = x;
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  initial begin
    int cyc;
    int v;
    reset_n = 1'b1;
    os_sel  = 3'd1;
    data_in = 16'sd1234;

    // Reset holds outputs at zero, first strobe at edge 8, DC 100 settles
    repeat (3) begin
      @(negedge clk);
      check("rst_data_out", longint'(data_out), 0);
      check("rst_clk_div", longint'(clk_div), 0);
    end
    reset_n = 1'b0;
    data_in = 16'sd100;
    wait_strobe(600, cyc);
    check("first_strobe_os1", cyc, 8);
    for (int k = 2; k <= 5; k++) begin
      wait_strobe(600, cyc);
      check("period_os1", cyc, 8);
    end
    check("dc_100", longint'(data_out), 100);
    @(negedge clk);
    check("strobe_one_cycle", longint'(clk_div), 0);

    // Zero input stays zero
    do_reset(3'd1, 16'sd0);
    for (int k = 0; k < 6; k++) begin
      wait_strobe(600, cyc);
      check("dc_zero", longint'(data_out), 0);
    end

    // Ratio 4 with a varying pattern, then DC -7
    do_reset(3'd0, 16'sd0);
    for (int i = 0; i < 80; i++) begin
      v = ((i * 7919) % 65536) - 32768;
      data_in = DW'(v);
      @(negedge clk);
    end
    data_in = -16'sd7;
    for (int k = 0; k < 6; k++) begin
      wait_strobe(600, cyc);
      if (k > 0) check("period_os0", cyc, 4);
    end
    check("dc_minus7", longint'(data_out), -7);

    // Full scale at ratio 512
    do_reset(3'd7, -16'sd32768);
    for (int k = 1; k <= 5; k++) begin
      wait_strobe(600, cyc);
      check("period_os7", cyc, 512);
    end
    check("dc_neg_full", longint'(data_out), -32768);
    data_in = 16'sd32767;
    for (int k = 1; k <= 5; k++) wait_strobe(600, cyc);
    check("dc_pos_full", longint'(data_out), 32767);

    // Ratio change mid-period from 8 to 32
    do_reset(3'd1, 16'sd500);
    for (int k = 1; k <= 5; k++) wait_strobe(600, cyc);
    check("dc_500_pre", longint'(data_out), 500);
    repeat (3) @(negedge clk);
    os_sel = 3'd3;
    wait_strobe(600, cyc);
    check("tail_period", cyc, 5);
    for (int k = 2; k <= 5; k++) begin
      wait_strobe(600, cyc);
      check("period_os3", cyc, 32);
    end
    check("dc_500_post", longint'(data_out), 500);

    // Reset in the middle of a DC run
    do_reset(3'd2, 16'sd200);
    for (int k = 1; k <= 5; k++) wait_strobe(600, cyc);
    check("dc_200_pre", longint'(data_out), 200);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_data_out", longint'(data_out), 0);
    check("mid_rst_clk_div", longint'(clk_div), 0);
    reset_n = 1'b0;
    wait_strobe(600, cyc);
    check("first_strobe_os2", cyc, 16);
    for (int k = 2; k <= 5; k++) wait_strobe(600, cyc);
    check("dc_200_post", longint'(data_out), 200);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_filter.md
Name: cic_filter

Overview:
- Hogenauer CIC decimation filter: 3 integrator stages, 3 comb stages, differential delay 1.
- Sits between the high-rate sample source (one signed sample per clk cycle) and the low-rate processing path.
- Decimation ratio is runtime-selectable via os_sel.
- Output is normalized to unity DC gain and qualified by a one-cycle strobe.

Parameters:
- DW, 16, width of data_in and data_out in bits (signed two's complement).

Ports:
- clk  input  1  single clock for all logic; one input sample per rising edge.
- reset_n  input  1  synchronous, active-high reset. The name is kept as the codebase does; reset is asserted when reset_n == 1.
- os_sel  input  3  decimation select: R = 2^(os_sel+2), i.e. 0→4, 1→8, … 7→512.
- data_in  input  DW  signed input sample, consumed every clk cycle.
- data_out  output  DW  signed decimated, normalized output sample; holds between strobes.
- clk_div  output  1  decimated-rate strobe, high for exactly one cycle when data_out takes a new value.

Behaviour:
- All state updates on the rising edge of clk. No other clocks; clk_div is a registered strobe, not a clock.
- Reset (reset_n == 1 at an edge):
  - integrators, comb delay registers, decimation counter, data_out and clk_div all clear to 0.
  - The active ratio is loaded from os_sel.
  - Reset mid-operation discards all history.
- Internal width W = DW + 27 (3 × log2(512)). All integrator and comb arithmetic is modulo 2^W; wrap-around in the integrators is intentional and correct.
- data_in is sign-extended to W.
- Integrators, every cycle, registered pipeline:
  - I1 <= I1 + data_in
  - I2 <= I2 + I1
  - I3 <= I3 + I2
- Decimation counter:
  - Counts 0 … R−1 and wraps.
  - At the edge where cnt == R−1, the strobe event occurs.
  - First strobe occurs at the R-th edge after reset deasserts.
- Strobe event, same edge:
  - C1 = I3 − D1, C2 = C1 − D2, C3 = C2 − D3 (combinational).
  - D1 <= I3, D2 <= C1, D3 <= C2.
  - data_out <= normalized C3.
  - clk_div <= 1; clk_div <= 0 on all other edges.
- Normalization:
  - Shift S = 3 × (os_sel_active + 2), arithmetic right shift of C3 by S, truncation toward −∞.
  - Take the low DW bits.
  - Gain R^3 = 2^S exactly, so a DC input x yields x after settling. No saturation is needed for in-range inputs.
- os_sel handling:
  - Sampled into os_sel_active only at reset and at each strobe edge.
  - A new value takes effect for the next decimation period; the counter restarts at 0.
  - Comb delays are not cleared, so a transient of up to 4 output samples is allowed after a ratio change.
- Latency: a step at data_in is fully reflected in data_out by the 5th strobe after the step is applied.

Optional Feature:
- Macro CIC_ROUND_EN.
- Defined: normalization adds 2^(S−1) to C3 before the arithmetic shift, giving round-half-up instead of truncation. The W-bit width still suffices; no extra guard bit is needed because only the low DW bits are kept.
- Undefined: plain truncating arithmetic shift.
- DC-input results are identical either way.

Test Plan:
- Reset check:
  - Hold reset_n=1 for 3 cycles with data_in=1234 → data_out=0, clk_div=0 throughout.
  - After release, first clk_div pulse at exactly the 8th edge with os_sel=1.
- Strobe period:
  - os_sel=1 → clk_div high 1 cycle every 8 cycles.
  - os_sel=7 → clk_div high 1 cycle every 512 cycles.
  - os_sel=0 → clk_div high 1 cycle every 4 cycles.
- DC gain:
  - os_sel=1, data_in constant 100 → data_out == 100 from the 5th strobe onward.
  - data_in=0 → data_out stays 0.
- Full-scale at max ratio:
  - os_sel=7, data_in constant −32768 → data_out == −32768 from the 5th strobe onward; no overflow artefacts.
  - data_in=32767 → data_out == 32767.
- Ratio change:
  - Settled at os_sel=1 with data_in=500, switch os_sel=3 mid-period.
  - Current period still ends at 8 cycles; subsequent periods are 32 cycles.
  - data_out == 500 again from the 5th strobe after the change.
- Reset mid-operation:
  - Assert reset_n for 1 cycle during a 200-valued DC run → data_out=0 immediately.
  - Re-settles to 200 by the 5th strobe after release.
